// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: memory read port plus the decoder-facing handshake.
// The master modport is the fetch unit; the slave modport is memory and decoder.
interface fetch_unit_if #(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic [REG_WIDTH-1:0]  x_in;
  logic [REG_WIDTH-1:0]  y_in;
  logic [REG_WIDTH-1:0]  instruction;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  operand;
  logic                  instruction_ready;
  logic                  instruction_done;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_value;
  logic [ADDR_WIDTH-1:0] pc;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    input  x_in,
    input  y_in,
    output instruction,
    output addr,
    output operand,
    output instruction_ready,
    input  instruction_done,
    input  pc_load,
    input  pc_load_value,
    output pc
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    output x_in,
    output y_in,
    input  instruction,
    input  addr,
    input  operand,
    input  instruction_ready,
    output instruction_done,
    output pc_load,
    output pc_load_value,
    input  pc
  );

endinterface

// File: rtl/fetch_unit.sv
// 6502 fetch stage: reads opcode/operands at pc, resolves the effective address.
// Define FETCH_RESET_VECTOR_EN to load pc from FFFC/FFFD after reset instead of RESET_PC.
module fetch_unit #(
  parameter int unsigned           REG_WIDTH  = 8,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(16'h0600)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_OP,
    S_DEC,
    S_LO,
    S_HI,
    S_PLO,
    S_PHI,
    S_READY,
    S_VLO,
    S_VHI,
    S_VPC
  } state_e;

  typedef enum logic [3:0] {
    M_IMP,
    M_IMM,
    M_ZP,
    M_ZPX,
    M_ZPY,
    M_ABS,
    M_ABSX,
    M_ABSY,
    M_INDX,
    M_INDY
  } mode_e;

  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0]  ONE_R   = REG_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] VEC_LO  = ADDR_WIDTH'(16'hFFFC);
  localparam logic [ADDR_WIDTH-1:0] VEC_HI  = ADDR_WIDTH'(16'hFFFD);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d, dec_mode;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]  instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  operand_q, operand_d;
  logic                  ready_q, ready_d;
  logic [REG_WIDTH-1:0]  lo_q, lo_d;
  logic [REG_WIDTH-1:0]  plo_q, plo_d;

  logic                  mem_rd_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [REG_WIDTH-1:0]  idx;
  logic [REG_WIDTH-1:0]  zp_sum;

  // Addressing mode from the {aaa,bbb,cc} opcode fields.
  function automatic mode_e decode_mode(input logic [REG_WIDTH-1:0] op);
    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic       use_y;
    mode_e      m;
    aaa   = op[7:5];
    bbb   = op[4:2];
    cc    = op[1:0];
    use_y = (cc == 2'b10) && ((aaa == 3'b100) || (aaa == 3'b101));
    m     = M_IMP;
    if (cc == 2'b01) begin
      case (bbb)
        3'b000:  m = M_INDX;
        3'b001:  m = M_ZP;
        3'b010:  m = M_IMM;
        3'b011:  m = M_ABS;
        3'b100:  m = M_INDY;
        3'b101:  m = M_ZPX;
        3'b110:  m = M_ABSY;
        default: m = M_ABSX;
      endcase
    end else if (cc != 2'b11) begin
      case (bbb)
        3'b000:  m = M_IMM;
        3'b001:  m = M_ZP;
        3'b011:  m = M_ABS;
        3'b101:  m = use_y ? M_ZPY : M_ZPX;
        3'b111:  m = use_y ? M_ABSY : M_ABSX;
        default: m = M_IMP;
      endcase
    end
    return m;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef FETCH_RESET_VECTOR_EN
      state_q <= S_VLO;
`else
      state_q <= S_OP;
`endif
      mode_q     <= M_IMP;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      operand_q  <= '0;
      ready_q    <= 1'b0;
      lo_q       <= '0;
      plo_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      operand_q  <= operand_d;
      ready_q    <= ready_d;
      lo_q       <= lo_d;
      plo_q      <= plo_d;
    end
  end

  // Next state, datapath updates and the memory read port.
  // The read port is combinational: the read issued in S_DEC depends on the opcode
  // arriving in that same cycle. mem_addr_q remembers the last issued address.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    operand_d  = operand_q;
    ready_d    = ready_q;
    lo_d       = lo_q;
    plo_d      = plo_q;
    mem_rd_c   = 1'b0;
    mem_addr_c = mem_addr_q;
    idx        = '0;
    zp_sum     = '0;
    dec_mode   = decode_mode(bus.mem_rdata);

    case (state_q)
      S_OP: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = pc_q;
        pc_d       = pc_q + ONE_A;
        state_d    = S_DEC;
      end

      S_DEC: begin
        instr_d = bus.mem_rdata;
        mode_d  = dec_mode;
        if (dec_mode == M_IMP) begin
          ready_d = 1'b1;
          state_d = S_READY;
        end else begin
          mem_rd_c   = 1'b1;
          mem_addr_c = pc_q;
          pc_d       = pc_q + ONE_A;
          state_d    = S_LO;
        end
      end

      S_LO: begin
        lo_d   = bus.mem_rdata;
        idx    = (mode_q == M_ZPY) ? bus.y_in : bus.x_in;
        zp_sum = bus.mem_rdata + idx;
        case (mode_q)
          M_IMM: begin
            operand_d = bus.mem_rdata;
            addr_d    = pc_q - ONE_A;
            ready_d   = 1'b1;
            state_d   = S_READY;
          end
          M_ZP: begin
            addr_d  = ADDR_WIDTH'(bus.mem_rdata);
            ready_d = 1'b1;
            state_d = S_READY;
          end
          M_ZPX, M_ZPY: begin
            addr_d  = ADDR_WIDTH'(zp_sum);
            ready_d = 1'b1;
            state_d = S_READY;
          end
          M_ABS, M_ABSX, M_ABSY: begin
            mem_rd_c   = 1'b1;
            mem_addr_c = pc_q;
            pc_d       = pc_q + ONE_A;
            state_d    = S_HI;
          end
          M_INDX: begin
            mem_rd_c   = 1'b1;
            mem_addr_c = ADDR_WIDTH'(zp_sum);
            state_d    = S_PLO;
          end
          M_INDY: begin
            mem_rd_c   = 1'b1;
            mem_addr_c = ADDR_WIDTH'(bus.mem_rdata);
            state_d    = S_PLO;
          end
          default: begin
            ready_d = 1'b1;
            state_d = S_READY;
          end
        endcase
      end

      S_HI: begin
        idx     = (mode_q == M_ABSX) ? bus.x_in : ((mode_q == M_ABSY) ? bus.y_in : '0);
        addr_d  = ADDR_WIDTH'({bus.mem_rdata, lo_q}) + ADDR_WIDTH'(idx);
        ready_d = 1'b1;
        state_d = S_READY;
      end

      S_PLO: begin
        // Pointer high byte comes from the next zero-page location, wrapping within page 0.
        plo_d      = bus.mem_rdata;
        zp_sum     = mem_addr_q[REG_WIDTH-1:0] + ONE_R;
        mem_rd_c   = 1'b1;
        mem_addr_c = ADDR_WIDTH'(zp_sum);
        state_d    = S_PHI;
      end

      S_PHI: begin
        idx     = (mode_q == M_INDY) ? bus.y_in : '0;
        addr_d  = ADDR_WIDTH'({bus.mem_rdata, plo_q}) + ADDR_WIDTH'(idx);
        ready_d = 1'b1;
        state_d = S_READY;
      end

      S_READY: begin
        if (bus.instruction_done) begin
          ready_d = 1'b0;
          pc_d    = bus.pc_load ? bus.pc_load_value : pc_q;
          state_d = S_OP;
        end
      end

`ifdef FETCH_RESET_VECTOR_EN
      S_VLO: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = VEC_LO;
        state_d    = S_VHI;
      end

      S_VHI: begin
        lo_d       = bus.mem_rdata;
        mem_rd_c   = 1'b1;
        mem_addr_c = VEC_HI;
        state_d    = S_VPC;
      end

      S_VPC: begin
        pc_d    = ADDR_WIDTH'({bus.mem_rdata, lo_q});
        state_d = S_OP;
      end
`endif

      default: state_d = S_OP;
    endcase

    if (mem_rd_c) begin
      mem_addr_d = mem_addr_c;
    end

    // No read may escape while reset is held; the address shows the cleared register.
    if (reset) begin
      mem_rd_c   = 1'b0;
      mem_addr_c = mem_addr_q;
    end
  end

  assign bus.mem_rd            = mem_rd_c;
  assign bus.mem_addr          = mem_addr_c;
  assign bus.instruction       = instr_q;
  assign bus.addr              = addr_q;
  assign bus.operand           = operand_q;
  assign bus.instruction_ready = ready_q;
  assign bus.pc                = pc_q;

`ifndef FETCH_RESET_VECTOR_EN
  logic unused_vec;
  assign unused_vec = ^{VEC_LO, VEC_HI};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle-latency byte memory.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rdata_q;
  logic [15:0] rd_log [$];

  fetch_unit_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (bus.mem_rd) rdata_q <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic release_and_wait_op(input string tag, input logic [15:0] exp_addr);
    bit found;
    found = 1'b0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_rd) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_found"}, 32'(found), 32'd1);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
  endtask

  // Called in the S_OP cycle; counts cycles until instruction_ready.
  task automatic exec(input string tag, input int exp_lat, input bit done_early);
    int n;
    n = 0;
    rd_log.delete();
    rd_log.push_back(bus.mem_addr);
    if (done_early) bus.instruction_done = 1'b1;
    while (n < 12 && !bus.instruction_ready) begin
      tick();
      n++;
      bus.instruction_done = 1'b0;
      if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic complete(input string tag, input bit load, input logic [15:0] value,
                          input logic [15:0] exp_addr);
    bus.instruction_done = 1'b1;
    bus.pc_load          = load;
    bus.pc_load_value    = value;
    tick();
    bus.instruction_done = 1'b0;
    bus.pc_load          = 1'b0;
    check({tag, "_rd"}, 32'(bus.mem_rd), 32'd1);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_addr));
    check({tag, "_rdy"}, 32'(bus.instruction_ready), 32'd0);
  endtask

  initial begin
    reset                = 1'b1;
    bus.x_in             = 8'h00;
    bus.y_in             = 8'h00;
    bus.instruction_done = 1'b0;
    bus.pc_load          = 1'b0;
    bus.pc_load_value    = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    do_reset();
    check("rst_ready", 32'(bus.instruction_ready), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
    check("rst_instr", 32'(bus.instruction), 32'h00);
    check("rst_addr", 32'(bus.addr), 32'h0000);
    check("rst_operand", 32'(bus.operand), 32'h00);
    check("rst_pc", 32'(bus.pc), 32'h0600);

`ifdef FETCH_RESET_VECTOR_EN
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'hC0;
    mem[16'hC000] = 8'hEA;
    release_and_wait_op("vec_lo", 16'hFFFC);
    tick();
    check("vec_hi_rd", 32'(bus.mem_rd), 32'd1);
    check("vec_hi_addr", 32'(bus.mem_addr), 32'hFFFD);
    tick();
    check("vec_gap_rd", 32'(bus.mem_rd), 32'd0);
    tick();
    check("vec_op_rd", 32'(bus.mem_rd), 32'd1);
    check("vec_op_addr", 32'(bus.mem_addr), 32'hC000);
    check("vec_pc", 32'(bus.pc), 32'hC000);
    exec("vec_nop", 2, 1'b0);
    check("vec_nop_instr", 32'(bus.instruction), 32'hEA);
    check("vec_nop_pc", 32'(bus.pc), 32'hC001);
    complete("vec_nop_done", 1'b0, 16'h0000, 16'hC001);
`else
    mem[16'h0600] = 8'hEA;
    release_and_wait_op("first_op", 16'h0600);
    exec("nop", 2, 1'b0);
    check("nop_instr", 32'(bus.instruction), 32'hEA);
    check("nop_pc", 32'(bus.pc), 32'h0601);
    complete("nop_done", 1'b0, 16'h0000, 16'h0601);

    // Program: LDA #42; LDA F0,X; ADC 12FF,X; LDA (FE,X); LDA (10),Y; LDA 1234
    mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h42;
    mem[16'h0602] = 8'hB5; mem[16'h0603] = 8'hF0;
    mem[16'h0604] = 8'h7D; mem[16'h0605] = 8'hFF; mem[16'h0606] = 8'h12;
    mem[16'h0607] = 8'hA1; mem[16'h0608] = 8'hFE;
    mem[16'h0609] = 8'hB1; mem[16'h060A] = 8'h10;
    mem[16'h060B] = 8'hAD; mem[16'h060C] = 8'h34; mem[16'h060D] = 8'h12;
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0010] = 8'h01; mem[16'h0011] = 8'h20;
    mem[16'h8000] = 8'hEA; mem[16'hFFFF] = 8'hEA;

    do_reset();
    release_and_wait_op("imm_op", 16'h0600);
    exec("imm", 3, 1'b0);
    check("imm_instr", 32'(bus.instruction), 32'hA9);
    check("imm_operand", 32'(bus.operand), 32'h42);
    check("imm_addr", 32'(bus.addr), 32'h0601);
    check("imm_pc", 32'(bus.pc), 32'h0602);
    complete("imm_done", 1'b0, 16'h0000, 16'h0602);

    bus.x_in = 8'h20;
    exec("zpx", 3, 1'b0);
    check("zpx_addr", 32'(bus.addr), 32'h0010);
    complete("zpx_done", 1'b0, 16'h0000, 16'h0604);

    bus.x_in = 8'h01;
    exec("absx", 4, 1'b0);
    check("absx_addr", 32'(bus.addr), 32'h1300);
    check("absx_pc", 32'(bus.pc), 32'h0607);
    complete("absx_done", 1'b0, 16'h0000, 16'h0607);

    exec("indx", 5, 1'b0);
    check("indx_addr", 32'(bus.addr), 32'h1234);
    check("indx_nreads", 32'(rd_log.size()), 32'd4);
    check("indx_ptr_lo", 32'(rd_log[2]), 32'h00FF);
    check("indx_ptr_hi", 32'(rd_log[3]), 32'h0000);
    complete("indx_done", 1'b0, 16'h0000, 16'h0609);

    bus.y_in = 8'hFF;
    exec("indy", 5, 1'b0);
    check("indy_addr", 32'(bus.addr), 32'h2100);
    check("indy_ptr_lo", 32'(rd_log[2]), 32'h0010);
    check("indy_ptr_hi", 32'(rd_log[3]), 32'h0011);
    tick();
    tick();
    check("hold_ready", 32'(bus.instruction_ready), 32'd1);
    check("hold_addr", 32'(bus.addr), 32'h2100);
    check("hold_rd", 32'(bus.mem_rd), 32'd0);
    complete("indy_done", 1'b0, 16'h0000, 16'h060B);

    // Abort LDA abs in S_HI (OP, DEC, LO, HI).
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_ready", 32'(bus.instruction_ready), 32'd0);
    check("abort_pc", 32'(bus.pc), 32'h0600);
    check("abort_instr", 32'(bus.instruction), 32'h00);
    check("abort_addr", 32'(bus.addr), 32'h0000);
    release_and_wait_op("abort_op", 16'h0600);

    exec("imm2", 3, 1'b0);
    complete("jump", 1'b1, 16'h8000, 16'h8000);
    check("jump_pc", 32'(bus.pc), 32'h8000);
    exec("nop8000", 2, 1'b1);
    check("nop8000_instr", 32'(bus.instruction), 32'hEA);
    check("nop8000_pc", 32'(bus.pc), 32'h8001);

    complete("jmp_ffff", 1'b1, 16'hFFFF, 16'hFFFF);
    exec("nopffff", 2, 1'b0);
    check("wrap_pc", 32'(bus.pc), 32'h0000);
    complete("wrap_done", 1'b0, 16'h0000, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
